// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between instruction fetch (I) and data load/store (D).
// One request is captured per transaction, forwarded to memory, and the
// response is routed back to the port that owns the transaction.
// At most one memory transaction is outstanding.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : round-robin tie-break using a last_owner register.
//               After reset last_owner = D, so I wins the first tie.
//   undefined : fixed priority, D always beats I.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   i_req/i_addr          fetch request (held until i_gnt)
//   i_gnt                 1-cycle pulse, fetch request captured
//   i_rvalid/i_rdata      fetch read data return
//   d_req/d_we/d_addr/    data request (held until d_gnt)
//   d_wdata
//   d_gnt                 1-cycle pulse, data request captured
//   d_rvalid/d_rdata      load data / store completion
//   m_req/m_we/m_addr/    memory request, accepted on m_req & m_ready
//   m_wdata/m_ready
//   m_rvalid/m_rdata      memory response (reads and writes)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]        state_r;
  logic              owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              we_r;
  logic              m_req_r;
  logic              i_gnt_r;
  logic              d_gnt_r;
  logic              i_rvalid_r;
  logic              d_rvalid_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              win_d_s;   // 1: D port wins the current arbitration

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_r;

  // Tie-break: on simultaneous requests the port that was not granted last wins.
  always_comb begin
    if (i_req && d_req) begin
      win_d_s = (last_owner_r == OWN_I);
    end else begin
      win_d_s = d_req;
    end
  end

  // Remember which port received the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_r <= OWN_D;
    end else if ((state_r == ST_IDLE) && (i_req || d_req)) begin
      last_owner_r <= win_d_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  // Fixed priority: a data request always beats a fetch request.
  always_comb begin
    win_d_s = d_req;
  end
`endif

  // Transaction FSM: capture in IDLE, present to memory in ISSUE, await response in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWN_D;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      we_r       <= 1'b0;
      m_req_r    <= 1'b0;
      i_gnt_r    <= 1'b0;
      d_gnt_r    <= 1'b0;
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      i_rdata_r  <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      // gnt and rvalid are single-cycle pulses
      i_gnt_r    <= 1'b0;
      d_gnt_r    <= 1'b0;
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_req || d_req) begin
            owner_r <= win_d_s;
            m_req_r <= 1'b1;
            state_r <= ST_ISSUE;
            if (win_d_s) begin
              addr_r  <= d_addr;
              wdata_r <= d_wdata;
              we_r    <= d_we;
              d_gnt_r <= 1'b1;
            end else begin
              addr_r  <= i_addr;
              wdata_r <= {DATA_W{1'b0}};
              we_r    <= 1'b0;
              i_gnt_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // Captured fields stay untouched while memory stalls, keeping m_* stable.
          if (m_ready) begin
            m_req_r <= 1'b0;
            we_r    <= 1'b0;
            state_r <= ST_RESP;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_RESP: begin
          if (m_rvalid) begin
            state_r <= ST_IDLE;
            if (owner_r == OWN_D) begin
              d_rdata_r  <= m_rdata;
              d_rvalid_r <= 1'b1;
            end else begin
              i_rdata_r  <= m_rdata;
              i_rvalid_r <= 1'b1;
            end
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          m_req_r <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt    = i_gnt_r;
  assign d_gnt    = d_gnt_r;
  assign i_rvalid = i_rvalid_r;
  assign d_rvalid = d_rvalid_r;
  assign i_rdata  = i_rdata_r;
  assign d_rdata  = d_rdata_r;
  assign m_req    = m_req_r;
  assign m_we     = we_r;
  assign m_addr   = addr_r;
  assign m_wdata  = wdata_r;

endmodule
